eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
- Transmit-side Ethernet framer in the clk125 (TX) domain; the transmit counterpart of the RGMII receive path.
- Takes a payload byte stream (dest MAC through end of payload) over a valid/ready/last handshake.
- Emits a complete GMII-style byte stream to the RGMII TX encoder: preamble, SFD, payload, zero padding, CRC-32 FCS, and an enforced inter-frame gap.

Parameters:
- MIN_PAYLOAD_BYTES, 60, minimum bytes before FCS; shorter frames are zero-padded.
- MAX_PAYLOAD_BYTES, 1514, maximum bytes before FCS; longer frames are aborted.
- IFG_BYTES, 12, minimum idle cycles between the last FCS byte and the next preamble.
- PAD_EN, 1'b1, 1 enables padding; 0 sends short frames unpadded.

Ports:
- clk125In  in  1  125 MHz TX clock.
- rstBIn  in  1  reset, asynchronous assert, active-low.
- txDataIn  in  8  payload byte.
- txDataValidIn  in  1  payload byte valid.
- txDataLastIn  in  1  marks the final payload byte of a frame.
- txDataReadyOut  out  1  byte accepted when valid and ready are both high.
- txDataOut  out  8  byte to RGMII TX.
- txDataValidOut  out  1  GMII TX_EN equivalent.
- txErrOut  out  1  GMII TX_ER equivalent.
- underrunOut  out  1  one-cycle pulse on payload underrun.
- oversizeOut  out  1  one-cycle pulse on oversize abort.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, CRC register 0xFFFFFFFF. Reset mid-frame abandons the frame; nothing resumes after release.
- Registered outputs: a byte accepted in cycle N appears on txDataOut in cycle N+1.
- IDLE -> PREAMBLE on txDataValidIn=1 while the IFG counter is satisfied. The first 0x55 appears on the cycle after valid is seen.
- PREAMBLE: 7 cycles of 0x55, then SFD 0xD5. txDataReadyOut rises in the cycle 0xD5 is on txDataOut.
- PAYLOAD:
  - ready=1; each accepted byte is output and fed to the CRC; counter increments.
  - On accepted last: go to PAD if PAD_EN and count<MIN_PAYLOAD_BYTES, else go to FCS.
- PAD: output 0x00, fed to the CRC, until count==MIN_PAYLOAD_BYTES, then FCS. ready=0.
- FCS: 4 bytes of ~CRC, LSB byte first (bit-reflected CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF). Then IFG.
- IFG:
  - txDataValidOut=0 for at least IFG_BYTES cycles, counted from the cycle after the last FCS byte.
  - txDataValidIn high during IFG is held off (ready=0) until the gap completes.
  - Back-to-back frames therefore start exactly IFG_BYTES idle cycles apart.
- Underrun (txDataValidIn=0 in PAYLOAD):
  - That cycle outputs txErrOut=1 with txDataValidOut=1; underrunOut pulses.
  - No FCS is sent; go to DROP.
- Oversize (an accepted byte would make count>MAX_PAYLOAD_BYTES without last):
  - That byte is replaced by txErrOut=1 with txDataValidOut=1; oversizeOut pulses; go to DROP.
- DROP:
  - ready=1; bytes are discarded (txDataValidOut=0) until an accepted byte with last, then IFG.
  - If the erroring byte itself carried last, go straight to IFG.
- txErrOut is 0 in every other cycle; txDataValidOut is 1 only from the first preamble byte to the last FCS byte, plus error cycles.
- Counter width is $clog2(MAX_PAYLOAD_BYTES+2); it never wraps within legal frames.
- Upstream (a FIFO) must not change txDataIn/txDataLastIn while valid=1 and ready=0.

Decomposition:
- pkg.sv holds:
  - typedef enum for states IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DROP, IFG;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY=32'h04C11DB7, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
- One combinational sub-module, crc32_d8: byte-wide reflected CRC-32 next-state, reusable by the RX FCS checker.

Test Plan:
- PAD_EN=0, payload ASCII "123456789" (0x31..0x39) -> output 7×0x55, 0xD5, 9 payload bytes, FCS 0x26 0x39 0xF4 0xCB; txDataValidOut high for exactly 21 cycles.
- PAD_EN=1, 14-byte payload -> 46 bytes of 0x00 pad; 60 bytes before FCS; FCS matches the bench CRC model over the padded frame; total 72 valid cycles.
- Two 64-byte frames presented back-to-back with valid held high -> exactly 12 cycles with txDataValidOut=0 between the last FCS byte and the next 0x55.
- valid dropped after 20 payload bytes, resumed later with last at byte 30 -> one cycle with txErrOut=1; underrunOut pulses; no FCS; bytes 21-30 consumed silently; then IFG.
- 1600-byte stream with last on byte 1600 -> 1514 bytes sent; byte 1515 slot has txErrOut=1; oversizeOut pulses; remaining bytes dropped; then IFG.
- rstBIn asserted mid-PAYLOAD -> outputs 0 immediately (async); after release, a new frame starts with a full preamble and a correct FCS.

Source files
------------

// File: rtl/eth_tx_framer_pkg.sv
// Shared types and constants for the Ethernet TX framer and the related RX FCS checker.
package eth_tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int PREAMBLE_LEN = 7;
    localparam int FCS_LEN      = 4;

    // Bit-reverse a 32-bit word; turns the normal-form polynomial into the LSB-first form.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload-in / GMII-out signal bundle of the TX framer.
interface eth_tx_framer_if;
    logic [7:0] txDataIn;
    logic       txDataValidIn;
    logic       txDataLastIn;
    logic       txDataReadyOut;
    logic [7:0] txDataOut;
    logic       txDataValidOut;
    logic       txErrOut;
    logic       underrunOut;
    logic       oversizeOut;

    // Upstream source / GMII sink side.
    modport master (
        output txDataIn, txDataValidIn, txDataLastIn,
        input  txDataReadyOut, txDataOut, txDataValidOut, txErrOut, underrunOut, oversizeOut
    );

    // Framer side.
    modport slave (
        input  txDataIn, txDataValidIn, txDataLastIn,
        output txDataReadyOut, txDataOut, txDataValidOut, txErrOut, underrunOut, oversizeOut
    );
endinterface

// File: rtl/eth_tx_framer_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state (LSB of the byte enters first).
module crc32_d8
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    // Eight unrolled shift/xor steps of the LSB-first LFSR.
    always_comb begin : crc_step
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Transmit framer: wraps a payload stream with preamble/SFD, pad and FCS, then holds the IFG.
//
// state    | meaning
// IDLE     | waiting for payload valid; gap already satisfied
// PREAMBLE | loading 0x55 bytes 2..7
// SFD      | loading 0xD5
// PAYLOAD  | ready=1, forwarding bytes into the CRC
// PAD      | appending 0x00 up to the minimum length
// FCS      | sending ~CRC, LSB byte first
// DROP     | discarding the rest of an errored frame up to last
// IFG      | enforced idle gap after the frame
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int MIN_PAYLOAD_BYTES = 60,
    parameter int MAX_PAYLOAD_BYTES = 1514,
    parameter int IFG_BYTES         = 12,
    parameter bit PAD_EN            = 1'b1
) (
    input  logic            clk125In,
    input  logic            rstBIn,
    eth_tx_framer_if.slave  bus_if
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD_BYTES + 2);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_LEN - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      crc_q, crc_d, crc_next, crc_inv;
    logic [7:0]       data_q, data_d, crc_byte, fcs_byte;
    logic             valid_q, valid_d, err_q, err_d;
    logic             underrun_q, underrun_d, oversize_q, oversize_d;
    logic             ready;

    assign ready    = (state_q == PAYLOAD) || (state_q == DROP);
    assign cnt_inc  = cnt_q + 1'b1;
    assign crc_byte = (state_q == PAD) ? 8'h00 : bus_if.txDataIn;
    assign crc_inv  = ~crc_q;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_next)
    );

    // Pick the FCS byte by position, LSB byte first.
    always_comb begin
        fcs_byte = crc_inv[7:0];
        case (cnt_q[1:0])
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            2'd3:    fcs_byte = crc_inv[31:24];
            default: fcs_byte = crc_inv[7:0];
        endcase
    end

    // Next state, counter, CRC and next registered output byte.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        data_d     = 8'h00;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.txDataValidIn) begin
                    state_d = PREAMBLE;
                    cnt_d   = CNT_W'(1);
                    crc_d   = CRC32_INIT;
                    data_d  = PREAMBLE_BYTE;
                    valid_d = 1'b1;
                end
            end
            PREAMBLE: begin
                data_d  = PREAMBLE_BYTE;
                valid_d = 1'b1;
                cnt_d   = cnt_inc;
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end
            end
            SFD: begin
                data_d  = SFD_BYTE;
                valid_d = 1'b1;
                state_d = PAYLOAD;
            end
            PAYLOAD: begin
                valid_d = 1'b1;
                if (!bus_if.txDataValidIn) begin
                    err_d      = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = DROP;
                    cnt_d      = '0;
                end else if (cnt_q == MAX_C) begin
                    // The byte that would exceed the maximum becomes the error slot.
                    err_d      = 1'b1;
                    oversize_d = 1'b1;
                    state_d    = bus_if.txDataLastIn ? IFG : DROP;
                    cnt_d      = '0;
                end else begin
                    data_d = bus_if.txDataIn;
                    crc_d  = crc_next;
                    cnt_d  = cnt_inc;
                    if (bus_if.txDataLastIn) begin
                        if (PAD_EN && (cnt_inc < MIN_C)) begin
                            state_d = PAD;
                        end else begin
                            state_d = FCS;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            PAD: begin
                data_d  = 8'h00;
                valid_d = 1'b1;
                crc_d   = crc_next;
                cnt_d   = cnt_inc;
                if (cnt_inc == MIN_C) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
            FCS: begin
                data_d  = fcs_byte;
                valid_d = 1'b1;
                cnt_d   = cnt_inc;
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end
            end
            DROP: begin
                if (bus_if.txDataValidIn && bus_if.txDataLastIn) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end
            end
            IFG: begin
                cnt_d = cnt_inc;
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk125In or negedge rstBIn) begin
        if (!rstBIn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            crc_q      <= CRC32_INIT;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
        end
    end

    assign bus_if.txDataReadyOut = ready;
    assign bus_if.txDataOut      = data_q;
    assign bus_if.txDataValidOut = valid_q;
    assign bus_if.txErrOut       = err_q;
    assign bus_if.underrunOut    = underrun_q;
    assign bus_if.oversizeOut    = oversize_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: one unpadded and one padded instance.
module tb_eth_tx_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    eth_tx_framer_if b0();
    eth_tx_framer_if b1();

    eth_tx_framer #(.PAD_EN(1'b0)) dut0 (.clk125In(clk), .rstBIn(rst_n), .bus_if(b0));
    eth_tx_framer #(.PAD_EN(1'b1)) dut1 (.clk125In(clk), .rstBIn(rst_n), .bus_if(b1));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pay  [0:1599];
    logic [7:0] expb [0:63];

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         gaps1[$];
    int         idle1 = 0;
    bit         seen1 = 1'b0;
    int         err1 = 0, ur1 = 0, os1 = 0;

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (b0.txDataValidOut) q0.push_back({b0.txErrOut, b0.txDataOut});
        if (b1.txDataValidOut) begin
            if (seen1 && idle1 > 0) gaps1.push_back(idle1);
            seen1 = 1'b1;
            idle1 = 0;
            q1.push_back({b1.txErrOut, b1.txDataOut});
        end else begin
            idle1++;
        end
        if (b1.txErrOut)    err1++;
        if (b1.underrunOut) ur1++;
        if (b1.oversizeOut) os1++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ expb[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? b1.txDataReadyOut : b0.txDataReadyOut;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin
            b1.txDataValidIn = v; b1.txDataIn = d; b1.txDataLastIn = l;
        end else begin
            b0.txDataValidIn = v; b0.txDataIn = d; b0.txDataLastIn = l;
        end
    endtask

    task automatic clear_logs();
        @(posedge clk);
        q0.delete(); q1.delete(); gaps1.delete();
        idle1 = 0; seen1 = 1'b0; err1 = 0; ur1 = 0; os1 = 0;
    endtask

    task automatic idle_wait(input int n);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    // Streams pay[0..len-1]; optionally drops valid for gap_len cycles after gap_at bytes.
    task automatic drive_frame(input bit sel, input int len, input int gap_at, input int gap_len);
        int idx = 0;
        int gaps_left = gap_len;
        int budget = 0;
        while (idx < len && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (idx == gap_at && gaps_left > 0) begin
                set_in(sel, 1'b0, 8'h00, 1'b0);
                gaps_left--;
            end else begin
                set_in(sel, 1'b1, pay[idx], idx == len - 1);
                if (rdy(sel)) idx++;
            end
        end
        n_cmp++;
        if (idx !== len) begin
            n_bad++;
            $display("FAIL drive_timeout: accepted %0d of %0d bytes", idx, len);
        end
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++; if ({b1.txDataValidOut, b1.txErrOut, b1.txDataOut} !== 10'h000) begin
            n_bad++; $display("FAIL reset_out: got %h exp 000", {b1.txDataValidOut, b1.txErrOut, b1.txDataOut}); end
        n_cmp++; if ({b1.txDataReadyOut, b1.underrunOut, b1.oversizeOut} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b exp 000", {b1.txDataReadyOut, b1.underrunOut, b1.oversizeOut}); end
        n_cmp++; if ({b0.txDataValidOut, b0.txDataReadyOut} !== 2'b00) begin
            n_bad++; $display("FAIL reset_dut0: got %b exp 00", {b0.txDataValidOut, b0.txDataReadyOut}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({b1.txDataValidOut, b1.txDataReadyOut} !== 2'b00) begin
            n_bad++; $display("FAIL idle_after_reset: got %b exp 00", {b1.txDataValidOut, b1.txDataReadyOut}); end
    endtask

    task automatic test_nopad();
        logic [7:0] fcs [0:3];
        logic [7:0] e;
        fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        clear_logs();
        drive_frame(1'b0, 9, -1, 0);
        idle_wait(40);
        n_cmp++; if (q0.size() !== 21) begin
            n_bad++; $display("FAIL nopad_len: got %0d exp 21", q0.size()); end
        for (int i = 0; i < 21 && i < q0.size(); i++) begin
            if (i < 7)       e = 8'h55;
            else if (i == 7) e = 8'hD5;
            else if (i < 17) e = pay[i-8];
            else             e = fcs[i-17];
            n_cmp++; if (q0[i] !== {1'b0, e}) begin
                n_bad++; $display("FAIL nopad_byte[%0d]: got %h exp %h", i, q0[i], {1'b0, e}); end
        end
    endtask

    task automatic test_pad();
        logic [31:0] crc;
        logic [7:0]  e;
        for (int i = 0; i < 60; i++) begin
            if (i < 14) pay[i] = 8'hA0 + 8'(i);
            expb[i] = (i < 14) ? pay[i] : 8'h00;
        end
        crc = crc_model(60);
        clear_logs();
        drive_frame(1'b1, 14, -1, 0);
        idle_wait(80);
        n_cmp++; if (q1.size() !== 72) begin
            n_bad++; $display("FAIL pad_len: got %0d exp 72", q1.size()); end
        for (int i = 0; i < 72 && i < q1.size(); i++) begin
            if (i < 7)       e = 8'h55;
            else if (i == 7) e = 8'hD5;
            else if (i < 68) e = expb[i-8];
            else             e = crc[8*(i-68) +: 8];
            n_cmp++; if (q1[i] !== {1'b0, e}) begin
                n_bad++; $display("FAIL pad_byte[%0d]: got %h exp %h", i, q1[i], {1'b0, e}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] crc;
        for (int i = 0; i < 64; i++) begin
            pay[i]  = 8'(i * 7 + 3);
            expb[i] = pay[i];
        end
        crc = crc_model(64);
        clear_logs();
        drive_frame(1'b1, 64, -1, 0);
        drive_frame(1'b1, 64, -1, 0);
        idle_wait(40);
        n_cmp++; if (q1.size() !== 152) begin
            n_bad++; $display("FAIL b2b_len: got %0d exp 152", q1.size()); end
        n_cmp++; if (gaps1.size() !== 1) begin
            n_bad++; $display("FAIL b2b_gap_count: got %0d exp 1", gaps1.size()); end
        if (gaps1.size() > 0) begin
            n_cmp++; if (gaps1[0] !== 12) begin
                n_bad++; $display("FAIL b2b_gap: got %0d exp 12", gaps1[0]); end
        end
        if (q1.size() == 152) begin
            n_cmp++; if ({q1[76], q1[83]} !== {9'h055, 9'h0D5}) begin
                n_bad++; $display("FAIL b2b_preamble2: got %h %h exp 055 0d5", q1[76], q1[83]); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if ({q1[72+k], q1[148+k]} !== {1'b0, crc[8*k +: 8], 1'b0, crc[8*k +: 8]}) begin
                    n_bad++; $display("FAIL b2b_fcs[%0d]: got %h %h exp %h", k, q1[72+k], q1[148+k], crc[8*k +: 8]); end
            end
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 30; i++) pay[i] = 8'h10 + 8'(i);
        clear_logs();
        drive_frame(1'b1, 30, 20, 5);
        idle_wait(30);
        n_cmp++; if (q1.size() !== 29) begin
            n_bad++; $display("FAIL underrun_len: got %0d exp 29", q1.size()); end
        if (q1.size() == 29) begin
            n_cmp++; if (q1[28][8] !== 1'b1) begin
                n_bad++; $display("FAIL underrun_err_slot: got %b exp 1", q1[28][8]); end
            n_cmp++; if (q1[27] !== {1'b0, pay[19]}) begin
                n_bad++; $display("FAIL underrun_byte20: got %h exp %h", q1[27], {1'b0, pay[19]}); end
        end
        n_cmp++; if ({ur1, err1, os1} !== {32'd1, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL underrun_pulses: got ur=%0d err=%0d os=%0d exp 1 1 0", ur1, err1, os1); end
    endtask

    task automatic test_oversize();
        for (int i = 0; i < 1600; i++) pay[i] = 8'(i) ^ 8'h5A;
        clear_logs();
        drive_frame(1'b1, 1600, -1, 0);
        idle_wait(30);
        n_cmp++; if (q1.size() !== 1523) begin
            n_bad++; $display("FAIL oversize_len: got %0d exp 1523", q1.size()); end
        if (q1.size() == 1523) begin
            n_cmp++; if (q1[1522][8] !== 1'b1) begin
                n_bad++; $display("FAIL oversize_err_slot: got %b exp 1", q1[1522][8]); end
            n_cmp++; if ({q1[8], q1[1521]} !== {1'b0, pay[0], 1'b0, pay[1513]}) begin
                n_bad++; $display("FAIL oversize_bytes: got %h %h exp %h %h", q1[8], q1[1521], pay[0], pay[1513]); end
        end
        n_cmp++; if ({os1, err1, ur1} !== {32'd1, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL oversize_pulses: got os=%0d err=%0d ur=%0d exp 1 1 0", os1, err1, ur1); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] crc;
        int k = 0;
        for (int i = 0; i < 60; i++) begin
            pay[i]  = 8'hC0 + 8'(i);
            expb[i] = pay[i];
        end
        crc = crc_model(60);
        clear_logs();
        repeat (12) begin
            @(negedge clk);
            set_in(1'b1, 1'b1, pay[k], 1'b0);
            if (rdy(1'b1)) k++;
        end
        @(negedge clk);
        n_cmp++; if ({b1.txDataReadyOut, b1.txDataValidOut} !== 2'b11) begin
            n_bad++; $display("FAIL midframe_active: got %b exp 11", {b1.txDataReadyOut, b1.txDataValidOut}); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({b1.txDataReadyOut, b1.txDataValidOut, b1.txErrOut, b1.txDataOut} !== 11'h000) begin
            n_bad++; $display("FAIL async_reset: got %h exp 000", {b1.txDataReadyOut, b1.txDataValidOut, b1.txErrOut, b1.txDataOut}); end
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        drive_frame(1'b1, 60, -1, 0);
        idle_wait(30);
        n_cmp++; if (q1.size() !== 72) begin
            n_bad++; $display("FAIL post_reset_len: got %0d exp 72", q1.size()); end
        if (q1.size() == 72) begin
            n_cmp++; if ({q1[0], q1[6], q1[7], q1[8]} !== {9'h055, 9'h055, 9'h0D5, 1'b0, pay[0]}) begin
                n_bad++; $display("FAIL post_reset_head: got %h %h %h %h", q1[0], q1[6], q1[7], q1[8]); end
            for (int j = 0; j < 4; j++) begin
                n_cmp++; if (q1[68+j] !== {1'b0, crc[8*j +: 8]}) begin
                    n_bad++; $display("FAIL post_reset_fcs[%0d]: got %h exp %h", j, q1[68+j], crc[8*j +: 8]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nopad();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
